// File: rtl/pipe_pkg.sv
// Shared definitions for valid/ready pipeline stage registers.
// Holds the stage state encoding and the occupancy values it maps to.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(pipe_state_t s);
        case (s)
            ONE:     return OCC_ONE;
            FULL:    return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register (control + data group) with load and independent clears.
// Clears take priority over load so a flush always wins over a same-cycle move.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_ctrl_i,
    input  logic              clear_data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: the payload is reset too (not just the valid state) because the
    // data group is observable on out_data even while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for every flop so all registers
            // sample their pre-edge inputs regardless of statement order.
            if (clear_ctrl_i) begin
                ctrl_q <= '0;
            end else if (load_i) begin
                ctrl_q <= ctrl_i;
            end

            if (clear_data_i) begin
                data_q <= '0;
            end else if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready depends on registered state only, so backpressure never chains combinationally.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 24,
    parameter int DATA_W     = 400,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t state_q, state_d;

    logic in_fire, out_fire;
    logic main_load, main_from_skid, main_clr;
    logic skid_load, skid_clr;

    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] skid_data, main_data_in;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = occ_of(state_q);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    // Main goes idle: clear ctrl so the bubble shows no writes.
                    main_clr = 1'b1;
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush kills both slots and any same-cycle input; downstream still
        // consumed whatever it fired on.
        if (flush) begin
            state_d        = EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
            main_clr       = 1'b1;
            skid_clr       = 1'b1;
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk          (clk),
        .rst          (rst),
        .load_i       (main_load),
        .clear_ctrl_i (main_clr),
        .clear_data_i (CLEAR_DATA & main_clr),
        .ctrl_i       (main_ctrl_in),
        .data_i       (main_data_in),
        .ctrl_o       (out_ctrl),
        .data_o       (out_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .load_i       (skid_load),
        .clear_ctrl_i (skid_clr),
        .clear_data_i (CLEAR_DATA & skid_clr),
        .ctrl_i       (in_ctrl),
        .data_i       (in_data),
        .ctrl_o       (skid_ctrl),
        .data_o       (skid_data)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: two instances (CLEAR_DATA=0 and 1) share
// one stimulus stream; a queue-based model of up to two held entries predicts outputs.
module tb_pipe_skid_stage;

    localparam int CTRL_W = 24;
    localparam int DATA_W = 400;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        int                avail;
    } entry_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              in_ready0, in_ready1;
    logic              out_valid0, out_valid1;
    logic [CTRL_W-1:0] out_ctrl0, out_ctrl1;
    logic [DATA_W-1:0] out_data0, out_data1;
    logic [1:0]        occ0, occ1;

    entry_t            exp_q[$];
    entry_t            head;
    int                n_vis;
    int                cyc;
    logic [DATA_W-1:0] last_data;
    int                n_cmp;
    int                n_err;

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl0),
        .out_data  (out_data0),
        .occupancy (occ0)
    );

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl1),
        .out_data  (out_data1),
        .occupancy (occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i += 32) d = (d << 32) | DATA_W'($urandom);
        return d;
    endfunction

    // Compare one instance against the model's view of the visible head entry.
    task automatic check_dut(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                             input logic [DATA_W-1:0] d, input logic [1:0] occ,
                             input bit clear_data);
        logic [DATA_W-1:0] exp_d;
        check({tag, ".out_valid"}, DATA_W'(v), DATA_W'(n_vis > 0));
        check({tag, ".occupancy"}, DATA_W'(occ), DATA_W'(n_vis));
        check({tag, ".out_ctrl"}, DATA_W'(c), (n_vis > 0) ? DATA_W'(head.ctrl) : '0);
        if (n_vis > 0) exp_d = head.data;
        else if (clear_data) exp_d = '0;
        else exp_d = last_data;
        check({tag, ".out_data"}, d, exp_d);
    endtask

    // Monitor: one cycle's outputs checked just before the rising edge, then the
    // model advances by what that edge will do.
    always begin
        bit popped;
        @(negedge clk);
        #3;
        n_vis = 0;
        foreach (exp_q[i]) if (exp_q[i].avail <= cyc) n_vis++;
        if (n_vis > 0) head = exp_q[0];
        check_dut("d0", out_valid0, out_ctrl0, out_data0, occ0, 1'b0);
        check_dut("d1", out_valid1, out_ctrl1, out_data1, occ1, 1'b1);
        if (!rst) begin
            popped = 1'b0;
            if (n_vis > 0 && out_ready) begin
                last_data = exp_q[0].data;
                void'(exp_q.pop_front());
                popped = 1'b1;
            end
            if (flush) begin
                if (!popped && n_vis > 0) last_data = exp_q[0].data;
                exp_q.delete();
            end
        end
        cyc++;
    end

    // Driver: apply inputs after the falling edge; an accepted entry is pushed
    // into the scoreboard, visible to the monitor from the next cycle.
    task automatic cycle(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        bit model_ready;
        entry_t e;
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        model_ready = (exp_q.size() < 2);
        check("d0.in_ready", DATA_W'(in_ready0), DATA_W'(model_ready));
        check("d1.in_ready", DATA_W'(in_ready1), DATA_W'(model_ready));
        if (v && model_ready && !rst) begin
            e.ctrl  = c;
            e.data  = d;
            e.avail = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_data = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0;
        repeat (3) idle(1'b0);
        rst = 1'b0;

        // First transfer straight after reset.
        cycle(1'b1, CTRL_W'(24'h00A5), DATA_W'(16'h1234), 1'b1, 1'b0);
        idle(1'b1);

        // Sustained streaming.
        for (int i = 0; i < 8; i++) cycle(1'b1, CTRL_W'($urandom), rand_data(), 1'b1, 1'b0);
        idle(1'b1);

        // Fill the skid under backpressure, then drain.
        cycle(1'b1, CTRL_W'(24'h0000AA), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(24'h0000BB), rand_data(), 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        repeat (3) idle(1'b1);

        // Flush while FULL with an offered input C.
        cycle(1'b1, CTRL_W'(24'h000111), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(24'h000222), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(24'h000CCC), rand_data(), 1'b0, 1'b1);
        repeat (2) idle(1'b1);

        // Flush while ONE: data retained on d0, cleared on d1.
        cycle(1'b1, CTRL_W'(24'h000333), rand_data(), 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        idle(1'b1);

        // Asynchronous reset while FULL, checked before the next rising edge.
        cycle(1'b1, CTRL_W'(24'h000444), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(24'h000555), rand_data(), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        last_data = '0;
        #1;
        check("rst.d0.out_valid", DATA_W'(out_valid0), '0);
        check("rst.d0.out_ctrl", DATA_W'(out_ctrl0), '0);
        check("rst.d0.out_data", out_data0, '0);
        check("rst.d0.occupancy", DATA_W'(occ0), '0);
        check("rst.d0.in_ready", DATA_W'(in_ready0), DATA_W'(1'b1));
        check("rst.d1.out_valid", DATA_W'(out_valid1), '0);
        check("rst.d1.in_ready", DATA_W'(in_ready1), DATA_W'(1'b1));
        idle(1'b0);
        rst = 1'b0;
        idle(1'b1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(9) < 7, CTRL_W'($urandom), rand_data(),
                  $urandom_range(9) < 6, $urandom_range(19) == 0);
        end
        repeat (4) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshake and a two-entry skid buffer, replacing the fixed-field, enable-driven inter-stage registers between the IF/ID/EX/MEM/WB stages. Payload is split into a control group, cleared to a bubble on flush, and a data group, retained unless configured otherwise. No combinational path runs from `out_ready` to `in_ready`, so stages can be chained without long backpressure chains.

## Interface
- `CTRL_W`, 24: width of the control group (reg_write, mem_read/write, csr_write, pc_src, …); zeroed on flush/bubble.
- `DATA_W`, 400: width of the data group (pc, rs/rd, operands, imm, csr data).
- `CLEAR_DATA`, 0: 1 = data group is also zeroed on flush and whenever `out_valid`=0.

- `clk`  in  1  clock. Reset `rst` is asynchronous and active-high.
- `rst`  in  1  async reset, active-high.
- `flush`  in  1  synchronous kill of all held entries and of any same-cycle input.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; function of state only.
- `in_ctrl`  in  CTRL_W  upstream control group.
- `in_data`  in  DATA_W  upstream data group.
- `out_valid`  out  1  registered; main slot holds a live entry.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  registered; forced 0 when `out_valid`=0.
- `out_data`  out  DATA_W  registered main-slot data.
- `occupancy`  out  2  live entries held (0..2).

## Operation
- Two slots: main (drives outputs) and skid. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main live), FULL (main + skid live).
- `in_ready` = (state != FULL). `occupancy` = 0/1/2 per state.
- EMPTY: in_fire → main ← in, go ONE.
- ONE: in_fire & out_fire → main ← in, stay ONE. in_fire & !out_fire → skid ← in, go FULL. !in_fire & out_fire → go EMPTY. Otherwise hold.
- FULL: out_fire → main ← skid, go ONE (no input accepted this cycle, `in_ready`=0). Otherwise hold.
- Order preserved: skid entry always leaves after main entry.
- `flush` (priority over everything except `rst`): next state EMPTY, main and skid control zeroed; data retained (or zeroed if CLEAR_DATA=1); a same-cycle in_fire is discarded; a same-cycle out_fire still counts as consumed by downstream (downstream decides its own kill).
- Bubble rule: whenever `out_valid`=0, `out_ctrl`=0, so a downstream stage ignoring `out_valid` still sees no writes.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid cleared, `occupancy`=0, `in_ready`=1.
- Latency: in_fire in cycle N → `out_valid`=1 with that payload in cycle N+1.
- Throughput: one entry per cycle sustained while `out_ready`=1.
- Backpressure: `out_ready` dropping in cycle N is first reflected on `in_ready` in cycle N+1; the entry accepted in cycle N lands in skid.
- `out_valid`/`out_ctrl`/`out_data` must stay stable while out_valid & !out_ready, except under `flush`.
- `rst` mid-transfer: all entries lost immediately, outputs to reset values asynchronously.
- `flush` in FULL: both entries killed in one cycle, `in_ready`=1 next cycle.

## Structure
- Shared package `pipe_pkg`: `pipe_state_t` enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and occupancy constants; reused by all stage wrappers.
- Sub-module `pipe_slot`: one ctrl+data register with load, clear-ctrl and optional clear-data; instantiated twice (main, skid).
- Per-stage wrappers (e.g. ID→EX) pack named fields into `in_ctrl`/`in_data`.

## Test plan
- Reset release, in_valid=1, in_ctrl=0x00A5, in_data=0x1234, out_ready=1 → next cycle out_valid=1, out_ctrl=0x00A5, out_data=0x1234; occupancy=1.
- Stream 8 entries with out_ready=1 → 8 consecutive out_valid cycles, payloads in order, in_ready never 0.
- Accept A,B while out_ready=0 → occupancy=2, in_ready=0, outputs hold A; raise out_ready → A then B on consecutive cycles, in_ready=1 after B moves to main.
- FULL plus flush=1 with in_valid=1 (C) → next cycle out_valid=0, out_ctrl=0, occupancy=0, C never appears.
- CLEAR_DATA=1, flush in ONE → out_data=0 next cycle; CLEAR_DATA=0 → out_data retains last value, out_ctrl=0.
- Assert rst asynchronously mid-stream in FULL → outputs reach reset values before next clk edge; in_ready=1.
